// File: rtl/timer_apb_regs_if.sv
// APB bus bundle for the timer register block.
// The master drives the request; the slave returns read data and ready.
interface timer_apb_regs_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready
   );
endinterface

// File: rtl/timer_apb_regs.sv
// APB register file for the 8-bit timer: control/data/status/irq-enable/count.
// Drives timer_counter controls and turns overflow/underflow pulses into sticky flags.
module timer_apb_regs #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   timer_apb_regs_if.slave   apb,
   input  logic [DATA_W-1:0] cnt_val,
   input  logic              s_ovf,
   input  logic              s_udf,
   output logic              cnt_en,
   output logic              cnt_down,
   output logic [1:0]        cks,
   output logic              load,
   output logic [DATA_W-1:0] load_val,
   output logic              interrupt
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

   localparam logic [ADDR_W-1:0] ADDR_TCR  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_TDR  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TSR  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_TIE  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_TCNT = ADDR_W'(4);

   apb_state_e        state_q, state_d;
   logic [3:0]        tcr_q, tcr_d;
   logic [DATA_W-1:0] tdr_q, tdr_d;
   logic [1:0]        tsr_q, tsr_d;
   logic [1:0]        tie_q, tie_d;
   logic              load_q, load_d;
   logic              irq_q, irq_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;

   logic              setup_rd;
   logic              wr_en;
   logic [1:0]        tsr_clr;
   logic [DATA_W-1:0] rd_mux;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (apb.psel && !apb.penable) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = (apb.psel && !apb.penable) ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase

      // A commit needs a preceding setup phase, so a stray penable in IDLE is ignored.
      wr_en    = (state_q == SETUP) && apb.psel && apb.penable && apb.pwrite;
      setup_rd = apb.psel && !apb.penable && !apb.pwrite;

      rd_mux = '0;
      unique case (apb.paddr)
         ADDR_TCR:  rd_mux = DATA_W'(tcr_q);
         ADDR_TDR:  rd_mux = tdr_q;
         ADDR_TSR:  rd_mux = DATA_W'(tsr_q);
         ADDR_TIE:  rd_mux = DATA_W'(tie_q);
         ADDR_TCNT: rd_mux = cnt_val;
         default:   rd_mux = '0;
      endcase
      prdata_d = setup_rd ? rd_mux : '0;

      tcr_d  = tcr_q;
      tdr_d  = tdr_q;
      tie_d  = tie_q;
      load_d = 1'b0;
      if (wr_en) begin
         unique case (apb.paddr)
            ADDR_TCR: tcr_d = apb.pwdata[3:0];
            ADDR_TDR: begin
               tdr_d  = apb.pwdata;
               load_d = 1'b1;
            end
            ADDR_TIE: tie_d = apb.pwdata[1:0];
            default:  ;
         endcase
      end

      // Hardware set is OR-ed in after the clear so a coincident pulse wins.
      tsr_clr = (wr_en && apb.paddr == ADDR_TSR) ? apb.pwdata[1:0] : 2'b00;
      tsr_d   = (tsr_q & ~tsr_clr) | {s_udf, s_ovf};

      irq_d = |(tsr_q & tie_q);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q  <= IDLE;
         tcr_q    <= '0;
         tdr_q    <= '0;
         tsr_q    <= '0;
         tie_q    <= '0;
         load_q   <= 1'b0;
         irq_q    <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         tcr_q    <= tcr_d;
         tdr_q    <= tdr_d;
         tsr_q    <= tsr_d;
         tie_q    <= tie_d;
         load_q   <= load_d;
         irq_q    <= irq_d;
         prdata_q <= prdata_d;
      end
   end

   assign apb.prdata = prdata_q;
   assign apb.pready = 1'b1;
   assign cnt_en     = tcr_q[0];
   assign cnt_down   = tcr_q[1];
   assign cks        = tcr_q[3:2];
   assign load       = load_q;
   assign load_val   = tdr_q;
   assign interrupt  = irq_q;

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed bench for timer_apb_regs: APB reads/writes, load strobe, RW1C flags,
// interrupt timing and reset during a transfer, all with hand-computed expectations.
module tb_timer_apb_regs;

   logic       pclk;
   logic       presetn;
   logic [7:0] cnt_val;
   logic       s_ovf;
   logic       s_udf;
   logic       cnt_en;
   logic       cnt_down;
   logic [1:0] cks;
   logic       load;
   logic [7:0] load_val;
   logic       interrupt;

   int unsigned checks;
   int unsigned errors;
   logic [7:0]  rd;

   timer_apb_regs_if #(.ADDR_W(8), .DATA_W(8)) apb ();

   timer_apb_regs #(.ADDR_W(8), .DATA_W(8)) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .apb       (apb),
      .cnt_val   (cnt_val),
      .s_ovf     (s_ovf),
      .s_udf     (s_udf),
      .cnt_en    (cnt_en),
      .cnt_down  (cnt_down),
      .cks       (cks),
      .load      (load),
      .load_val  (load_val),
      .interrupt (interrupt)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change on negedges; the DUT samples them on the following posedge.
   task automatic apb_write(input logic [7:0] addr, input logic [7:0] data, input logic udf_in_access);
      @(negedge pclk);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
      apb.paddr = addr; apb.pwdata = data;
      @(negedge pclk);
      apb.penable = 1'b1;
      s_udf = udf_in_access;
      @(negedge pclk);
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      s_udf = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [7:0] data);
      @(negedge pclk);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0;
      apb.paddr = addr;
      @(negedge pclk);
      apb.penable = 1'b1;
      data = apb.prdata;
      check("pready_read", {7'd0, apb.pready}, 8'h01);
      @(negedge pclk);
      apb.psel = 1'b0; apb.penable = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      presetn = 1'b0;
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      apb.paddr = 8'h00; apb.pwdata = 8'h00;
      cnt_val = 8'h00; s_ovf = 1'b0; s_udf = 1'b0;
      repeat (3) @(negedge pclk);

      check("rst_prdata", apb.prdata, 8'h00);
      check("rst_pready", {7'd0, apb.pready}, 8'h01);
      check("rst_load", {7'd0, load}, 8'h00);
      check("rst_irq", {7'd0, interrupt}, 8'h00);
      check("rst_cnt_en", {7'd0, cnt_en}, 8'h00);
      presetn = 1'b1;

      // Every register and a spread of reserved addresses read zero after reset.
      for (int i = 0; i < 5; i++) begin
         apb_read(8'(i), rd);
         check("rst_read_reg", rd, 8'h00);
      end
      apb_read(8'h05, rd); check("rst_read_05", rd, 8'h00);
      apb_read(8'h80, rd); check("rst_read_80", rd, 8'h00);
      apb_read(8'hFF, rd); check("rst_read_ff", rd, 8'h00);
      check("rst_irq_after", {7'd0, interrupt}, 8'h00);

      cnt_val = 8'h3C;
      apb_read(8'h04, rd); check("tcnt", rd, 8'h3C);
      apb_write(8'h04, 8'h77, 1'b0);
      apb_read(8'h04, rd); check("tcnt_ro", rd, 8'h3C);

      apb_write(8'h00, 8'hFF, 1'b0);
      check("tcr_cnt_en", {7'd0, cnt_en}, 8'h01);
      check("tcr_cnt_down", {7'd0, cnt_down}, 8'h01);
      check("tcr_cks", {6'd0, cks}, 8'h03);
      apb_read(8'h00, rd); check("tcr_read", rd, 8'h0F);
      apb_write(8'h07, 8'hAA, 1'b0);
      apb_read(8'h07, rd); check("rsvd_read", rd, 8'h00);
      apb_read(8'h00, rd); check("tcr_unchanged", rd, 8'h0F);

      apb_write(8'h01, 8'hF0, 1'b0);
      check("load_hi", {7'd0, load}, 8'h01);
      check("load_val", load_val, 8'hF0);
      @(negedge pclk);
      check("load_one_cycle", {7'd0, load}, 8'h00);
      apb_read(8'h01, rd); check("tdr_read", rd, 8'hF0);
      check("no_load_on_read", {7'd0, load}, 8'h00);

      apb_write(8'h03, 8'h01, 1'b0);
      @(negedge pclk);
      s_ovf = 1'b1;
      @(negedge pclk);
      s_ovf = 1'b0;
      check("irq_after_set_edge", {7'd0, interrupt}, 8'h00);
      @(negedge pclk);
      check("irq_two_edges", {7'd0, interrupt}, 8'h01);
      apb_read(8'h02, rd); check("tsr_ovf", rd, 8'h01);
      apb_write(8'h02, 8'h02, 1'b0);
      apb_read(8'h02, rd); check("tsr_w1c_other", rd, 8'h01);
      apb_write(8'h02, 8'h01, 1'b0);
      check("irq_hold_at_clear", {7'd0, interrupt}, 8'h01);
      @(negedge pclk);
      check("irq_fall", {7'd0, interrupt}, 8'h00);
      apb_read(8'h02, rd); check("tsr_cleared", rd, 8'h00);

      // Underflow pulse coincides with the commit edge of a UDF clear.
      apb_write(8'h03, 8'h00, 1'b0);
      apb_write(8'h02, 8'h02, 1'b1);
      apb_read(8'h02, rd); check("tsr_set_wins", rd, 8'h02);
      repeat (2) @(negedge pclk);
      check("irq_masked", {7'd0, interrupt}, 8'h00);

      // Back-to-back: write TIE then read it with no idle cycle between.
      @(negedge pclk);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
      apb.paddr = 8'h03; apb.pwdata = 8'h03;
      @(negedge pclk);
      apb.penable = 1'b1;
      @(negedge pclk);
      apb.penable = 1'b0; apb.pwrite = 1'b0;
      @(negedge pclk);
      apb.penable = 1'b1;
      check("b2b_read", apb.prdata, 8'h03);
      @(negedge pclk);
      apb.psel = 1'b0; apb.penable = 1'b0;
      check("b2b_irq", {7'd0, interrupt}, 8'h01);

      // Reset lands in the access phase of a TCR write.
      @(negedge pclk);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
      apb.paddr = 8'h00; apb.pwdata = 8'h03;
      @(negedge pclk);
      apb.penable = 1'b1;
      #1 presetn = 1'b0;
      #1;
      check("midrst_cnt_en", {7'd0, cnt_en}, 8'h00);
      check("midrst_irq", {7'd0, interrupt}, 8'h00);
      @(negedge pclk);
      check("midrst_load", {7'd0, load}, 8'h00);
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      presetn = 1'b1;
      apb_read(8'h00, rd); check("midrst_tcr", rd, 8'h00);
      apb_read(8'h02, rd); check("midrst_tsr", rd, 8'h00);
      apb_write(8'h00, 8'h03, 1'b0);
      apb_read(8'h00, rd); check("post_rst_tcr", rd, 8'h03);
      check("post_rst_cnt_en", {7'd0, cnt_en}, 8'h01);
      check("post_rst_cnt_down", {7'd0, cnt_down}, 8'h01);
      check("post_rst_cks", {6'd0, cks}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
